// File: rtl/ifetch_pkg.sv
// Shared widths, queue-entry payload and PC helpers for the fetch front end.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned PC_INC  = 4;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // Sequential successor; wraps naturally at 2**PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(PC_INC);
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Decode-side handshake bus of the prefetch unit.
interface fetch_prefetch_unit_if
  import ifetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_pc_plus_4;
  logic [CNT_W-1:0]   queue_count;

  // Fetch unit side: presents the queue head, receives acceptance.
  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus_4,
    output queue_count,
    input  out_ready
  );

  // Decode side: consumes the queue head.
  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus_4,
    input  queue_count,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch buffer with push, pop and single-cycle flush.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              push_ok;

  // A pop needs an entry; a push needs a free slot or a concurrent pop.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  // Next pointers and occupancy; flush empties the buffer outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !reset) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with local instruction memory, prefetch queue and redirect.
module fetch_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned    IMEM_AW     = 6,
  parameter int unsigned    QUEUE_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  fetch_prefetch_unit_if.master out_if
);

  localparam int unsigned IMEM_DEPTH = 2 ** IMEM_AW;
  localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1);

  logic [INSTR_W-1:0] imem_q [IMEM_DEPTH];
  logic [PC_W-1:0]    fpc_q, fpc_d;
  logic [IMEM_AW-1:0] rd_idx;
  logic [CNT_W-1:0]   count;
  logic               head_valid;
  logic               pop;
  logic               push;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

  // Program load port; deliberately unaffected by reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  // Upper PC bits are dropped, so fetch addresses alias modulo memory size.
  assign rd_idx     = fpc_q[IMEM_AW+1:2];
  assign push_entry = '{instr: imem_q[rd_idx], pc: fpc_q};

  assign head_valid = (count != '0);
  assign pop        = head_valid && out_if.out_ready;
  assign push       = !redirect_valid && ((count < CNT_W'(QUEUE_DEPTH)) || pop);

  // Fetch PC advance: redirect wins, otherwise step only when an entry is queued.
  always_comb begin
    fpc_d = fpc_q;
    if (redirect_valid) fpc_d = word_align(redirect_target);
    else if (push)      fpc_d = pc_next(fpc_q);
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) fpc_q <= RESET_PC;
    else       fpc_q <= fpc_d;
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  // Head presentation; payload is zeroed while the queue is empty.
  assign out_if.out_valid     = head_valid;
  assign out_if.out_instr     = head_valid ? head.instr : '0;
  assign out_if.out_pc        = head_valid ? head.pc : '0;
  assign out_if.out_pc_plus_4 = head_valid ? pc_next(head.pc) : '0;
  assign out_if.queue_count   = count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: directed phases push expected transfers,
// a negedge monitor pops and compares each accepted head entry.
module tb_fetch_prefetch_unit;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  fetch_prefetch_unit_if #(.QUEUE_DEPTH(4)) bus ();

  fetch_prefetch_unit #(
    .IMEM_AW     (6),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_if          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [31:0] instr, input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_xfer: got pc %h, none expected", bus.out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("xfer_pc", bus.out_pc, mon_e.pc);
          check("xfer_instr", bus.out_instr, mon_e.instr);
          check("xfer_pc_plus_4", bus.out_pc_plus_4, mon_e.pc + 32'd4);
        end
      end else if (!bus.out_valid) begin
        check("idle_payload_zero", bus.out_pc | bus.out_instr | bus.out_pc_plus_4, 32'h0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    imem_we         = 1'b0;
    imem_waddr      = '0;
    imem_wdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    bus.out_ready   = 1'b0;

    // Program load while held in reset: imem[i] = 0x1000_0000 + i.
    for (int i = 0; i < 64; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 6'(i);
      imem_wdata = 32'h1000_0000 + 32'(i);
      cycle();
    end
    imem_we = 1'b0;
    cycle();

    // Reset state.
    @(negedge clk);
    check("reset_count", 32'(bus.queue_count), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_pc", bus.out_pc, 32'd0);
    mon_en = 1'b1;

    // Free run from reset: one sequential instruction per cycle.
    for (int i = 0; i < 8; i++) expect_xfer(32'h1000_0000 + 32'(i), 32'(4 * i));
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (9) cycle();
    bus.out_ready = 1'b0;
    check("sb_empty_freerun", 32'(exp_q.size()), 32'd0);

    // Back-pressure: queue saturates at four, then drains without gaps.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (10) cycle();
    @(negedge clk);
    check("full_count", 32'(bus.queue_count), 32'd4);
    check("full_head_pc", bus.out_pc, 32'h0);
    cycle();
    expect_xfer(32'h1000_0000, 32'h00);
    expect_xfer(32'h1000_0001, 32'h04);
    expect_xfer(32'h1000_0002, 32'h08);
    expect_xfer(32'h1000_0003, 32'h0C);
    expect_xfer(32'h1000_0004, 32'h10);
    expect_xfer(32'h1000_0005, 32'h14);
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    bus.out_ready = 1'b0;
    check("sb_empty_drain", 32'(exp_q.size()), 32'd0);

    // Redirect to unaligned 0x22 while full: head transfers, flush, then 0x20.
    expect_xfer(32'h1000_0006, 32'h18);
    bus.out_ready   = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0022;
    cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_bubble_valid", 32'(bus.out_valid), 32'd0);
    check("redir_bubble_count", 32'(bus.queue_count), 32'd0);
    expect_xfer(32'h1000_0008, 32'h20);
    cycle();
    cycle();
    bus.out_ready = 1'b0;
    check("sb_empty_redirect", 32'(exp_q.size()), 32'd0);

    // Redirect near the top of memory: index wraps 63 -> 0.
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_00FC;
    cycle();
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b1;
    expect_xfer(32'h1000_003F, 32'h0000_00FC);
    expect_xfer(32'h1000_0000, 32'h0000_0100);
    expect_xfer(32'h1000_0001, 32'h0000_0104);
    repeat (4) cycle();
    bus.out_ready = 1'b0;
    check("sb_empty_alias", 32'(exp_q.size()), 32'd0);

    // Redirect to the last word of the address space: PC wraps to zero.
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b1;
    expect_xfer(32'h1000_003F, 32'hFFFF_FFFC);
    expect_xfer(32'h1000_0000, 32'h0000_0000);
    repeat (3) cycle();
    bus.out_ready = 1'b0;
    check("sb_empty_wrap", 32'(exp_q.size()), 32'd0);

    // Reset with a concurrent redirect: reset wins.
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    cycle();
    @(negedge clk);
    check("rst_redir_count", 32'(bus.queue_count), 32'd0);
    check("rst_redir_valid", 32'(bus.out_valid), 32'd0);
    check("rst_redir_instr", bus.out_instr, 32'd0);
    check("rst_redir_pc4", bus.out_pc_plus_4, 32'd0);
    expect_xfer(32'h1000_0000, 32'h00);
    expect_xfer(32'h1000_0001, 32'h04);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b0;
    repeat (3) cycle();
    check("sb_empty_final", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameter IMEM_AW, default 6, instruction-memory word-address width (depth 2**IMEM_AW words).
REQ-002 Parameter QUEUE_DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, fetch PC after reset.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_we  in  1  instruction-memory write enable (program load).
REQ-007 imem_waddr  in  IMEM_AW  word address for write.
REQ-008 imem_wdata  in  32  instruction word to write.
REQ-009 redirect_valid  in  1  branch/jump redirect request.
REQ-010 redirect_target  in  32  redirect byte address.
REQ-011 out_valid  out  1  head queue entry valid.
REQ-012 out_ready  in  1  decode stage accepts head entry.
REQ-013 out_instr  out  32  head instruction.
REQ-014 out_pc  out  32  byte address of head instruction.
REQ-015 out_pc_plus_4  out  32  out_pc + 4, mod 2**32.
REQ-016 queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries.

Function
REQ-017 Internal fetch PC (fpc); read index = fpc[IMEM_AW+1:2]; upper bits ignored, so addresses alias modulo memory size.
REQ-018 Memory read is combinational; a write takes effect at the clock edge, so a same-cycle read of the written address returns the old word.
REQ-019 Transfer = out_valid & out_ready; pop = transfer.
REQ-020 Push when redirect_valid=0 and (queue_count < QUEUE_DEPTH or pop); entry = {imem[index], fpc}; fpc <= fpc + 4, wrapping at 2**32.
REQ-021 Full (queue_count = QUEUE_DEPTH) and no pop: no push, fpc holds.
REQ-022 Simultaneous push and pop: queue_count unchanged; when full, the pop frees the slot for the push in the same cycle.
REQ-023 Redirect: a same-cycle transfer still completes; all entries then flush (queue_count <= 0, pointers equal); no push; fpc <= {redirect_target[31:2], 2'b00}.
REQ-024 Redirect latency: redirect at cycle N gives out_valid=0 at N+1 and the target instruction at the head with out_valid=1 at N+2, provided out_ready held no push back.
REQ-025 Back-to-back redirects: the last one wins; each redirect flushes.
REQ-026 out_valid = (queue_count != 0); when 0, out_instr, out_pc and out_pc_plus_4 are driven to 0.
REQ-027 FIFO order preserved; pointers wrap modulo QUEUE_DEPTH.
REQ-028 Steady state with out_ready=1 throughout: one instruction per cycle, sequential PCs.

Reset
REQ-029 When reset=1 at an edge: fpc <= RESET_PC, queue_count <= 0, pointers <= 0, so out_valid=0, out_instr/out_pc/out_pc_plus_4=0 the next cycle.
REQ-030 Reset overrides redirect, push and pop in the same cycle; memory contents are not reset, and imem writes are still honoured during reset.
REQ-031 First cycle after reset deassertion pushes RESET_PC, so out_valid=1 one cycle later.

Structure
REQ-032 Shared package ifetch_pkg holds INSTR_W=32, PC_W=32, PC_INC=4 and the queue-entry struct {instr, pc}.
REQ-033 Queue is a sub-module fetch_queue: circular buffer with push, pop, flush, count, parametrised by QUEUE_DEPTH and entry type.
REQ-034 Top holds fpc, instruction memory, push/redirect control; total RTL is 120-400 lines.

Verification
REQ-035 Load imem[0..7]=32'h1000_0000+i, reset, out_ready=1 -> out_pc 0,4,8,... with matching instr, one per cycle from cycle 1.
REQ-036 out_ready=0 for 10 cycles after reset -> queue_count saturates at 4, fpc=0x10; release gives pc 0,4,8,C,10 in order with no gap.
REQ-037 Redirect to 0x0000_0022 while full and out_ready=1 -> head transfers, flush, out_valid=0 next cycle, then out_pc=0x20 one cycle later.
REQ-038 IMEM_AW=6, redirect to 0xFC then free-run -> out_pc 0xFC, 0x100 with instr imem[63] then imem[0].
REQ-039 Redirect to 0xFFFF_FFFC -> out_pc_plus_4=0, next out_pc=0x0000_0000.
REQ-040 Assert reset mid-stream with redirect_valid=1 -> queue_count=0, out_valid=0 the next cycle, first entry after release has out_pc=RESET_PC.
